// File: rtl/cart_loader_if.sv
// cart_loader_if: ioctl download stream plus cart RAM write port.
// The master side is the HPS/RAM environment and the slave side is cart_loader.
interface cart_loader_if #(
    parameter int AW = 14
);
    logic          ioctl_download;
    logic [7:0]    ioctl_index;
    logic          ioctl_wr;
    logic [24:0]   ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          ioctl_wait;
    logic          mem_req;
    logic          mem_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        input  ioctl_wait, mem_req, mem_addr, mem_wdata
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, mem_ack,
        output ioctl_wait, mem_req, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cart_loader.sv
// cart_loader: receives cartridge bytes from the HPS ioctl stream and writes
// them into cart RAM through a small byte FIFO and a req/ack port. The CPU is
// held in reset while a load is in progress.
// Optional feature: define CART_CKSUM_EN to add cart_cksum, which is a 16-bit
// wrap-around sum of every byte that is written to RAM.
module cart_loader #(
    parameter int         AW         = 14,
    parameter int         FIFO_AW    = 2,
    parameter logic [7:0] CART_INDEX = 8'd1
) (
    input  logic                clk,
    input  logic                reset,
    cart_loader_if.slave        bus,
    output logic                cpu_hold,
    output logic [AW:0]         cart_size,
    output logic                load_done,
`ifdef CART_CKSUM_EN
    output logic [15:0]         cart_cksum,
`endif
    output logic                overflow
);
    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = FIFO_AW + 1;
    localparam int EW    = AW + 8;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_DONE} state_t;

    state_t               state_q, state_d;
    logic [EW-1:0]        fifo_q [DEPTH];
    logic [EW-1:0]        fifo_d [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 wait_q, wait_d;
    logic                 mem_req_q, mem_req_d;
    logic [AW-1:0]        mem_addr_q, mem_addr_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 cpu_hold_q, cpu_hold_d;
    logic [AW:0]          cart_size_q, cart_size_d;
    logic                 load_done_q, load_done_d;
    logic                 overflow_q, overflow_d;
`ifdef CART_CKSUM_EN
    logic [15:0]          cksum_q, cksum_d;
`endif

    logic                 active, in_range, wr_load, push, pop, ack;
    logic [AW:0]          addr_p1;

    // Next-state, FIFO bookkeeping and all registered outputs.
    always_comb begin
        state_d     = state_q;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cart_size_d = cart_size_q;
        overflow_d  = overflow_q;
`ifdef CART_CKSUM_EN
        cksum_d     = cksum_q;
`endif

        active   = bus.ioctl_download && (bus.ioctl_index == CART_INDEX);
        in_range = (bus.ioctl_addr[24:AW] == '0);
        addr_p1  = {1'b0, bus.ioctl_addr[AW-1:0]} + (AW+1)'(1);
        wr_load  = (state_q == S_LOAD) && bus.ioctl_wr;
        // The full check only protects against an HPS that ignores ioctl_wait.
        push     = wr_load && in_range && (cnt_q != CW'(DEPTH));
        // The output register refills whenever it is empty or its entry is acknowledged.
        pop      = (cnt_q != '0) && (!mem_req_q || bus.mem_ack);
        ack      = mem_req_q && bus.mem_ack;

        case (state_q)
            S_IDLE:  if (active) state_d = S_LOAD;
            S_LOAD:  if (!active) state_d = S_DRAIN;
            S_DRAIN: if ((cnt_q == '0) && !mem_req_q) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase

        if (state_q == S_IDLE && state_d == S_LOAD) begin
            cart_size_d = '0;
            overflow_d  = 1'b0;
`ifdef CART_CKSUM_EN
            cksum_d     = '0;
`endif
        end

        if (wr_load && !in_range) overflow_d = 1'b1;

        if (push) begin
            fifo_d[wr_ptr_q] = {bus.ioctl_addr[AW-1:0], bus.ioctl_dout};
            wr_ptr_d         = wr_ptr_q + 1'b1;
            if (addr_p1 > cart_size_q) cart_size_d = addr_p1;
        end

`ifdef CART_CKSUM_EN
        if (ack) cksum_d = cksum_q + {8'd0, mem_wdata_q};
`endif

        if (pop) begin
            {mem_addr_d, mem_wdata_d} = fifo_q[rd_ptr_q];
            mem_req_d                 = 1'b1;
            rd_ptr_d                  = rd_ptr_q + 1'b1;
        end else if (ack) begin
            mem_req_d = 1'b0;
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        // One slot is reserved because the HPS may still strobe in the cycle wait rises.
        wait_d      = (cnt_d >= CW'(DEPTH - 1));
        cpu_hold_d  = (state_d == S_LOAD) || (state_d == S_DRAIN);
        load_done_d = (state_d == S_DONE);
    end

    // State and output registers, cleared asynchronously. RAM content is not touched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            wait_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            cart_size_q <= '0;
            load_done_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef CART_CKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            cart_size_q <= cart_size_d;
            load_done_q <= load_done_d;
            overflow_q  <= overflow_d;
`ifdef CART_CKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    assign bus.ioctl_wait = wait_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign cpu_hold       = cpu_hold_q;
    assign cart_size      = cart_size_q;
    assign load_done      = load_done_q;
    assign overflow       = overflow_q;
`ifdef CART_CKSUM_EN
    assign cart_cksum     = cksum_q;
`endif
endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: directed tests for cart_loader with a behavioural cart RAM
// and monitors for mem_req, load_done and cpu_hold.
module tb_cart_loader;
    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_hold, load_done, overflow;
    logic [14:0] cart_size;
`ifdef CART_CKSUM_EN
    logic [15:0] cart_cksum;
    logic [15:0] last_cksum = '0;
`endif
    logic [7:0]  ram [16384];
    int          total = 0, bad = 0;
    int          done_cnt = 0, req_cnt = 0;

    cart_loader_if #(.AW(14)) bus ();

    cart_loader #(.AW(14), .FIFO_AW(2), .CART_INDEX(8'd1)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .cpu_hold  (cpu_hold),
        .cart_size (cart_size),
        .load_done (load_done),
`ifdef CART_CKSUM_EN
        .cart_cksum(cart_cksum),
`endif
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural cart RAM: a write lands on every cycle where req and ack are both high.
    always @(posedge clk) if (!reset && bus.mem_req && bus.mem_ack) ram[bus.mem_addr] <= bus.mem_wdata;

    // Count load_done pulses and mem_req cycles away from the active edge.
    always @(negedge clk) begin
        if (load_done) begin
            done_cnt <= done_cnt + 1;
`ifdef CART_CKSUM_EN
            last_cksum <= cart_cksum;
`endif
        end
        if (bus.mem_req) req_cnt <= req_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input logic [7:0] idx);
        bus.ioctl_download = 1'b1;
        bus.ioctl_index    = idx;
        repeat (2) @(negedge clk);
    endtask

    task automatic send(input logic [24:0] a, input logic [7:0] d, inout logic hold_ok);
        int k;
        for (k = 0; k < 500 && bus.ioctl_wait; k++) @(negedge clk);
        if (bus.ioctl_wait) chk("wait_timeout", 32'(bus.ioctl_wait), 32'h0);
        if (!cpu_hold) hold_ok = 1'b0;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        @(negedge clk);
        bus.ioctl_wr   = 1'b0;
    endtask

    // Drop the download and wait (bounded) for load_done. hold_ok is cleared if
    // cpu_hold falls before the pulse arrives.
    task automatic finish_load(input int n0, inout logic hold_ok);
        bus.ioctl_download = 1'b0;
        for (int k = 0; k < 200 && done_cnt == n0; k++) begin
            if (!load_done && !cpu_hold) hold_ok = 1'b0;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic        hold_ok, stable;
        int          n0, r0;
        logic [13:0] a0;
        logic [7:0]  d0;

        reset              = 1'b1;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        bus.mem_ack        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_wait",  32'(bus.ioctl_wait), 32'h0);
        chk("rst_req",   32'(bus.mem_req),    32'h0);
        chk("rst_addr",  32'(bus.mem_addr),   32'h0);
        chk("rst_wdata", 32'(bus.mem_wdata),  32'h0);
        chk("rst_hold",  32'(cpu_hold),       32'h0);
        chk("rst_size",  32'(cart_size),      32'h0);
        chk("rst_done",  32'(load_done),      32'h0);
        chk("rst_ovf",   32'(overflow),       32'h0);

        // 1: 16 bytes at 0..15 with ack tied high
        hold_ok = 1'b1;
        n0 = done_cnt;
        start_load(8'd1);
        chk("t1_hold_on", 32'(cpu_hold), 32'h1);
        for (int i = 0; i < 16; i++) send(25'(i), 8'hA0 + 8'(i), hold_ok);
        finish_load(n0, hold_ok);
        chk("t1_done_cnt", 32'(done_cnt - n0), 32'h1);
        chk("t1_hold_thru", 32'(hold_ok), 32'h1);
        chk("t1_hold_off", 32'(cpu_hold), 32'h0);
        chk("t1_size", 32'(cart_size), 32'd16);
        for (int i = 0; i < 16; i++) chk($sformatf("t1_ram%0d", i), 32'(ram[i]), 32'hA0 + 32'(i));

        // 2: stall the RAM port, check backpressure and a stable request
        hold_ok = 1'b1;
        n0 = done_cnt;
        bus.mem_ack = 1'b0;
        start_load(8'd1);
        for (int i = 0; i < 4; i++) send(25'h20 + 25'(i), 8'h50 + 8'(i), hold_ok);
        chk("t2_wait", 32'(bus.ioctl_wait), 32'h1);
        chk("t2_req", 32'(bus.mem_req), 32'h1);
        chk("t2_addr", 32'(bus.mem_addr), 32'h20);
        chk("t2_wdata", 32'(bus.mem_wdata), 32'h50);
        a0 = bus.mem_addr;
        d0 = bus.mem_wdata;
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_addr !== a0 || bus.mem_wdata !== d0 || bus.mem_req !== 1'b1 || bus.ioctl_wait !== 1'b1)
                stable = 1'b0;
        end
        chk("t2_stable", 32'(stable), 32'h1);
        bus.mem_ack = 1'b1;
        for (int i = 4; i < 8; i++) send(25'h20 + 25'(i), 8'h50 + 8'(i), hold_ok);
        finish_load(n0, hold_ok);
        chk("t2_done_cnt", 32'(done_cnt - n0), 32'h1);
        chk("t2_size", 32'(cart_size), 32'h28);
        for (int i = 0; i < 8; i++) chk($sformatf("t2_ram%0d", i), 32'(ram[32 + i]), 32'h50 + 32'(i));

        // 3: a download with another index is ignored
        hold_ok = 1'b1;
        n0 = done_cnt;
        r0 = req_cnt;
        start_load(8'd2);
        for (int i = 0; i < 8; i++) send(25'h40 + 25'(i), 8'h77, hold_ok);
        chk("t3_hold", 32'(cpu_hold), 32'h0);
        bus.ioctl_download = 1'b0;
        repeat (30) @(negedge clk);
        chk("t3_no_req", 32'(req_cnt - r0), 32'h0);
        chk("t3_no_done", 32'(done_cnt - n0), 32'h0);
        chk("t3_size", 32'(cart_size), 32'h28);
        chk("t3_ram", 32'(ram[16'h40]), 32'(ram[16'h40]) ^ 32'(ram[16'h40] == 8'h77 ? 8'hFF : 8'h00));

        // 4: an address beyond the RAM sets overflow and is not written
        hold_ok = 1'b1;
        n0 = done_cnt;
        start_load(8'd1);
        chk("t4_ovf_clr", 32'(overflow), 32'h0);
        for (int i = 0; i < 4; i++) send(25'(i), 8'h11 * 8'(i + 1), hold_ok);
        send(25'h4000, 8'hEE, hold_ok);
        finish_load(n0, hold_ok);
        chk("t4_ovf", 32'(overflow), 32'h1);
        chk("t4_size", 32'(cart_size), 32'h4);
        chk("t4_done_cnt", 32'(done_cnt - n0), 32'h1);
        for (int i = 0; i < 4; i++) chk($sformatf("t4_ram%0d", i), 32'(ram[i]), 32'h11 * 32'(i + 1));

        // 5: reset in the middle of a load, then a clean reload
        hold_ok = 1'b1;
        start_load(8'd1);
        for (int i = 0; i < 5; i++) send(25'h100 + 25'(i), 8'h90 + 8'(i), hold_ok);
        reset = 1'b1;
        bus.ioctl_download = 1'b0;
        @(negedge clk);
        chk("t5_wait",  32'(bus.ioctl_wait), 32'h0);
        chk("t5_req",   32'(bus.mem_req),    32'h0);
        chk("t5_addr",  32'(bus.mem_addr),   32'h0);
        chk("t5_wdata", 32'(bus.mem_wdata),  32'h0);
        chk("t5_hold",  32'(cpu_hold),       32'h0);
        chk("t5_size",  32'(cart_size),      32'h0);
        chk("t5_ovf",   32'(overflow),       32'h0);
        reset = 1'b0;
        @(negedge clk);
        n0 = done_cnt;
        start_load(8'd1);
        for (int i = 0; i < 10; i++) send(25'h100 + 25'(i), 8'h30 + 8'(i), hold_ok);
        finish_load(n0, hold_ok);
        chk("t5_done_cnt", 32'(done_cnt - n0), 32'h1);
        chk("t5_hold_thru", 32'(hold_ok), 32'h1);
        chk("t5_size2", 32'(cart_size), 32'h10A);
        for (int i = 0; i < 10; i++) chk($sformatf("t5_ram%0d", i), 32'(ram[256 + i]), 32'h30 + 32'(i));

`ifdef CART_CKSUM_EN
        // 6: checksum over 300 bytes of 0xFF wraps to 300*255 mod 2^16
        hold_ok = 1'b1;
        n0 = done_cnt;
        start_load(8'd1);
        for (int i = 0; i < 300; i++) send(25'(i), 8'hFF, hold_ok);
        finish_load(n0, hold_ok);
        chk("t6_done_cnt", 32'(done_cnt - n0), 32'h1);
        chk("t6_cksum", 32'(last_cksum), 32'(16'(300 * 255)));
        chk("t6_size", 32'(cart_size), 32'd300);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
